// File: rtl/div_pkg.sv
// Shared definitions for the sequential unsigned restoring divider.
//
// Contents:
//   state_t        - control states of the divider (IDLE, RUN, DONE)
//   DIV0_QUOTIENT  - fill bit for the divide-by-zero quotient; it is
//                    replicated across the quotient to give all ones
//   cnt_width()    - width of the iteration counter for a given WIDTH
package div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Division by zero reports a quotient of all ones. The width is not
    // known here, so this is the single bit the top replicates.
    localparam logic DIV0_QUOTIENT = 1'b1;

    // The counter must be able to hold WIDTH-1. One bit is added above
    // the log so the helper is safe for any WIDTH.
    function automatic int cnt_width(input int width);
        return $clog2(width) + 1;
    endfunction

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division step.
//
// The partial remainder is shifted left by one and takes the next dividend
// bit. If the result is at least the divisor, the divisor is subtracted
// and the quotient bit is 1. Otherwise the shifted value is kept and the
// quotient bit is 0.
//
// Ports:
//   r_in   - current partial remainder (WIDTH+1 bits)
//   q_msb  - dividend bit shifted in on this step
//   d      - divisor
//   r_out  - next partial remainder (WIDTH+1 bits)
//   q_bit  - quotient bit produced by this step
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH:0]   r_in,
    input  logic             q_msb,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH:0]   r_out,
    output logic             q_bit
);

    logic [WIDTH:0] trial;
    logic [WIDTH:0] diff;

    // After every restoring step the remainder is below the divisor, so
    // the top bit of the incoming remainder is always zero. It is shifted
    // out here and is never needed.
    logic unused_r_msb;
    assign unused_r_msb = r_in[WIDTH];

    // The compare and subtract are WIDTH+1 bits wide. The shifted
    // remainder can then exceed 2^WIDTH-1 without overflowing.
    always_comb begin
        trial = {r_in[WIDTH-1:0], q_msb};
        diff  = trial - {1'b0, d};
        if (trial >= {1'b0, d}) begin
            r_out = diff;
            q_bit = 1'b1;
        end else begin
            r_out = trial;
            q_bit = 1'b0;
        end
    end

endmodule

// File: rtl/unsigned_divider.sv
// Sequential unsigned restoring divider, one quotient bit per clock.
//
// The operands are sampled on the edge that accepts start. A normal
// division runs for WIDTH RUN cycles, then raises done for one cycle.
// Division by zero goes straight to DONE. quotient, remainder and
// div_by_zero are registered. They change only when a result is produced
// or on reset, and otherwise hold.
//
// Ports:
//   clk          - rising-edge clock
//   reset        - synchronous, active-high reset
//   start        - request pulse, accepted in IDLE or DONE
//   dividend     - unsigned numerator
//   divisor      - unsigned denominator
//   busy         - high while a division is iterating (RUN)
//   done         - one-cycle pulse, results valid
//   quotient     - registered quotient
//   remainder    - registered remainder
//   div_by_zero  - registered flag belonging to the last result
module unsigned_divider
    import div_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CNT_W = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    state_t           state_q,       state_d;
    logic [WIDTH:0]   r_q,           r_d;
    logic [WIDTH-1:0] shift_q,       shift_d;
    logic [WIDTH-1:0] d_q,           d_d;
    logic [CNT_W-1:0] cnt_q,         cnt_d;
    logic [WIDTH-1:0] quotient_q,    quotient_d;
    logic [WIDTH-1:0] remainder_q,   remainder_d;
    logic             div_by_zero_q, div_by_zero_d;

    logic [WIDTH:0]   r_next;
    logic             q_bit;

    div_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .r_in  (r_q),
        .q_msb (shift_q[WIDTH-1]),
        .d     (d_q),
        .r_out (r_next),
        .q_bit (q_bit)
    );

    // DONE accepts a new start exactly like IDLE, so divisions can run
    // back to back. The shift register holds the unconsumed dividend bits
    // in its upper end. The quotient bits collect in its lower end.
    always_comb begin
        state_d       = state_q;
        r_d           = r_q;
        shift_d       = shift_q;
        d_d           = d_q;
        cnt_d         = cnt_q;
        quotient_d    = quotient_q;
        remainder_d   = remainder_q;
        div_by_zero_d = div_by_zero_q;

        case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (start) begin
                    if (divisor == '0) begin
                        state_d       = DONE;
                        quotient_d    = {WIDTH{DIV0_QUOTIENT}};
                        remainder_d   = dividend;
                        div_by_zero_d = 1'b1;
                    end else begin
                        state_d = RUN;
                        shift_d = dividend;
                        d_d     = divisor;
                        r_d     = '0;
                        cnt_d   = '0;
                    end
                end
            end

            RUN: begin
                r_d     = r_next;
                shift_d = {shift_q[WIDTH-2:0], q_bit};
                cnt_d   = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_CNT) begin
                    state_d       = DONE;
                    quotient_d    = {shift_q[WIDTH-2:0], q_bit};
                    remainder_d   = r_next[WIDTH-1:0];
                    div_by_zero_d = 1'b0;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Reset abandons any division in flight. It clears every register,
    // so no done pulse follows.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            r_q           <= '0;
            shift_q       <= '0;
            d_q           <= '0;
            cnt_q         <= '0;
            quotient_q    <= '0;
            remainder_q   <= '0;
            div_by_zero_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            r_q           <= r_d;
            shift_q       <= shift_d;
            d_q           <= d_d;
            cnt_q         <= cnt_d;
            quotient_q    <= quotient_d;
            remainder_q   <= remainder_d;
            div_by_zero_q <= div_by_zero_d;
        end
    end

    // Outputs depend only on registers.
    always_comb begin
        busy        = (state_q == RUN);
        done        = (state_q == DONE);
        quotient    = quotient_q;
        remainder   = remainder_q;
        div_by_zero = div_by_zero_q;
    end

endmodule

// File: tb/tb_unsigned_divider.sv
// Self-checking bench for unsigned_divider (WIDTH = 32).
// Expected results come from plain integer / and % in a reference model.
module tb_unsigned_divider;

    localparam int WIDTH = 32;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic [WIDTH-1:0]  dividend;
    logic [WIDTH-1:0]  divisor;
    logic              busy;
    logic              done;
    logic [WIDTH-1:0]  quotient;
    logic [WIDTH-1:0]  remainder;
    logic              div_by_zero;

    int assertions = 0;
    int failures   = 0;

    always #5 clk = ~clk;

    unsigned_divider #(.WIDTH(WIDTH)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    // Counts one comparison and reports it if the values differ.
    task automatic checkOutput(input string tag, input logic [63:0] actual,
                               input logic [63:0] expected);
        assertions++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Advances one clock and settles just after the rising edge.
    task automatic waitCycle();
        @(posedge clk);
        #1;
    endtask

    // Issues one start and waits for done, with a bounded wait.
    // glitchAt >= 0 pulses start with gn/gd while the division is running.
    // The operand inputs are scrambled after acceptance, so a result that
    // depends on late sampling is caught. Returns in the DONE cycle.
    task automatic applyStimulus(input logic [31:0] n, input logic [31:0] d,
                                 input int glitchAt,
                                 input logic [31:0] gn, input logic [31:0] gd,
                                 output int latency, output int busyCycles);
        int k;
        int holdErr;
        logic [31:0] holdQ;
        logic [31:0] holdR;
        logic        holdF;
        start    = 1'b1;
        dividend = n;
        divisor  = d;
        waitCycle();
        k          = 0;
        busyCycles = 0;
        holdErr    = 0;
        holdQ      = quotient;
        holdR      = remainder;
        holdF      = div_by_zero;
        start      = 1'b0;
        dividend   = $urandom;
        divisor    = $urandom;
        while (!done && k < 100) begin
            if (busy) busyCycles++;
            if (quotient !== holdQ || remainder !== holdR || div_by_zero !== holdF)
                holdErr++;
            if (k == glitchAt) begin
                start    = 1'b1;
                dividend = gn;
                divisor  = gd;
            end else begin
                start = 1'b0;
            end
            waitCycle();
            k++;
        end
        start   = 1'b0;
        latency = k;
        checkOutput("done_timeout", 64'(k >= 100), 64'd0);
        checkOutput("result_hold_during_run", 64'(holdErr), 64'd0);
    endtask

    // Reference model: plain arithmetic from the division rules.
    task automatic checkResult(input string tag, input logic [31:0] n,
                               input logic [31:0] d);
        logic [31:0] eq;
        logic [31:0] er;
        logic        ef;
        if (d == 32'd0) begin
            eq = 32'hFFFF_FFFF;
            er = n;
            ef = 1'b1;
        end else begin
            eq = n / d;
            er = n % d;
            ef = 1'b0;
        end
        checkOutput({tag, "_quotient"},  64'(quotient),    64'(eq));
        checkOutput({tag, "_remainder"}, 64'(remainder),   64'(er));
        checkOutput({tag, "_div0"},      64'(div_by_zero), 64'(ef));
        checkOutput({tag, "_identity"},
                    64'(quotient) * 64'(d) + 64'(remainder), 64'(n));
        if (d != 32'd0)
            checkOutput({tag, "_rem_lt_div"}, 64'(remainder < d), 64'd1);
    endtask

    initial begin
        int lat;
        int bcy;
        int doneSeen;
        logic [31:0] rn;
        logic [31:0] rd;
        logic [31:0] lastQ;
        logic [31:0] lastR;
        logic        lastF;

        reset    = 1'b1;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        waitCycle();
        waitCycle();
        checkOutput("reset_busy",      64'(busy),        64'd0);
        checkOutput("reset_done",      64'(done),        64'd0);
        checkOutput("reset_quotient",  64'(quotient),    64'd0);
        checkOutput("reset_remainder", 64'(remainder),   64'd0);
        checkOutput("reset_div0",      64'(div_by_zero), 64'd0);
        reset = 1'b0;
        waitCycle();

        // Basic division and its timing.
        applyStimulus(32'd100, 32'd7, -1, 32'd0, 32'd0, lat, bcy);
        checkOutput("basic_latency", 64'(lat), 64'd32);
        checkOutput("basic_busy_cycles", 64'(bcy), 64'd32);
        checkResult("basic", 32'd100, 32'd7);
        waitCycle();
        checkOutput("done_single_pulse", 64'(done), 64'd0);
        checkOutput("basic_held_quotient", 64'(quotient), 64'd14);

        // Extremes and boundaries.
        applyStimulus(32'hFFFF_FFFF, 32'd1, -1, 32'd0, 32'd0, lat, bcy);
        checkResult("max_div_1", 32'hFFFF_FFFF, 32'd1);
        applyStimulus(32'hFFFF_FFFF, 32'hFFFF_FFFF, -1, 32'd0, 32'd0, lat, bcy);
        checkResult("max_div_max", 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        applyStimulus(32'd5, 32'd9, -1, 32'd0, 32'd0, lat, bcy);
        checkResult("small_div_large", 32'd5, 32'd9);
        applyStimulus(32'h8000_0000, 32'd3, -1, 32'd0, 32'd0, lat, bcy);
        checkResult("msb_div_3", 32'h8000_0000, 32'd3);
        checkOutput("msb_div_3_const_q", 64'(quotient), 64'h2AAA_AAAA);
        applyStimulus(32'd0, 32'd17, -1, 32'd0, 32'd0, lat, bcy);
        checkResult("zero_dividend", 32'd0, 32'd17);
        waitCycle();

        // Divide by zero: immediate done, never busy.
        applyStimulus(32'd1234, 32'd0, -1, 32'd0, 32'd0, lat, bcy);
        checkOutput("div0_latency", 64'(lat), 64'd0);
        checkOutput("div0_busy_cycles", 64'(bcy), 64'd0);
        checkResult("div0", 32'd1234, 32'd0);
        waitCycle();
        checkOutput("div0_done_pulse", 64'(done), 64'd0);
        checkOutput("div0_no_busy_after", 64'(busy), 64'd0);
        checkOutput("div0_flag_held", 64'(div_by_zero), 64'd1);

        // Start during RUN is ignored; start in DONE is accepted.
        applyStimulus(32'd50, 32'd5, 5, 32'd9, 32'd2, lat, bcy);
        checkOutput("glitch_latency", 64'(lat), 64'd32);
        checkResult("glitch_ignored", 32'd50, 32'd5);
        applyStimulus(32'd9, 32'd2, -1, 32'd0, 32'd0, lat, bcy);
        checkOutput("b2b_latency", 64'(lat), 64'd32);
        checkResult("back_to_back", 32'd9, 32'd2);
        waitCycle();

        // Reset in the middle of a division.
        start    = 1'b1;
        dividend = 32'd1000;
        divisor  = 32'd3;
        waitCycle();
        start = 1'b0;
        repeat (9) waitCycle();
        reset = 1'b1;
        waitCycle();
        checkOutput("midreset_busy",      64'(busy),        64'd0);
        checkOutput("midreset_done",      64'(done),        64'd0);
        checkOutput("midreset_quotient",  64'(quotient),    64'd0);
        checkOutput("midreset_remainder", 64'(remainder),   64'd0);
        checkOutput("midreset_div0",      64'(div_by_zero), 64'd0);
        reset    = 1'b0;
        doneSeen = 0;
        for (int i = 0; i < 40; i++) begin
            waitCycle();
            if (done || busy) doneSeen++;
        end
        checkOutput("midreset_abandoned", 64'(doneSeen), 64'd0);
        applyStimulus(32'd1000, 32'd3, -1, 32'd0, 32'd0, lat, bcy);
        checkResult("after_reset", 32'd1000, 32'd3);

        // Random pairs, including zero, one and small divisors.
        for (int t = 0; t < 1000; t++) begin
            rn = $urandom;
            case ($urandom_range(0, 9))
                0:       rd = 32'd0;
                1:       rd = 32'd1;
                2:       rd = 32'($urandom_range(2, 15));
                3:       rd = $urandom;
                default: rd = $urandom >> $urandom_range(0, 31);
            endcase
            applyStimulus(rn, rd, ($urandom_range(0, 3) == 0) ? 10 : -1,
                          $urandom, $urandom, lat, bcy);
            checkOutput("rand_latency", 64'(lat), (rd == 32'd0) ? 64'd0 : 64'd32);
            checkResult("rand", rn, rd);
            lastQ = quotient;
            lastR = remainder;
            lastF = div_by_zero;
            if ($urandom_range(0, 1) == 1) begin
                waitCycle();
                checkOutput("rand_hold_idle",
                            64'({quotient, div_by_zero}) ^ 64'({remainder, 1'b0}),
                            64'({lastQ, lastF}) ^ 64'({lastR, 1'b0}));
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 assertions, failures);
        $finish;
    end

endmodule
